// File: rtl/uart_rx.sv
// uart_rx -- 8-bit asynchronous serial receiver with a single-entry output buffer.
//
// Frame: 1 start bit, 8 data bits LSB first, optional even-parity bit, 1 stop bit.
// Define UART_RX_PARITY_EN to receive 8E1 frames; without it frames are 8N1
// and parity_err is tied low.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (even, 4..65535)
// Ports:
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   rx           serial line input, idle high (asynchronous to clk)
//   data         received byte, stable while data_valid is high
//   data_valid   data holds a byte not yet consumed
//   data_ready   consumer accepts data when high together with data_valid
//   framing_err  one-cycle pulse: stop bit sampled low
//   overrun_err  one-cycle pulse: good byte dropped because the buffer was full
//   parity_err   one-cycle pulse: parity check failed (0 without parity)
//   busy         receiver is not idle
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t          state, state_nxt;
  logic            rx_m, rx_s;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_idx;
  logic [7:0]      sr;
  logic            shift_en;
  logic            stop_smp;
  logic            par_ok;
  logic            good;
  logic            full;

  // Two-flop synchronizer; resets to the idle line level so reset release
  // never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

`ifdef UART_RX_PARITY_EN
  logic par_en;
  logic par_bit;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    shift_en  = 1'b0;
    stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        // Half a bit in: confirm the start bit, then realign to mid-bit.
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt  = '0;
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state_nxt = PARITY;
`else
          if (bit_idx == 3'd7) state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt   = '0;
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        // Leave on the sample edge so a following start bit is not missed.
        if (cnt == FULL_LAST) begin
          cnt_nxt   = '0;
          stop_smp  = 1'b1;
          state_nxt = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // Hold off a break condition until the line returns high.
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign par_ok = ~(^sr ^ par_bit);
`else
  assign par_ok = 1'b1;
`endif

  assign good = stop_smp & rx_s & par_ok;
  // A full buffer that is not being drained this cycle cannot take a new byte.
  assign full = data_valid & ~data_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      bit_idx     <= '0;
      sr          <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      framing_err <= stop_smp & ~rx_s;
      overrun_err <= good & full;
      if (shift_en) begin
        sr      <= {rx_s, sr[7:1]};
        bit_idx <= bit_idx + 3'd1;   // wraps to 0 after bit 7, ready for next frame
      end
      if (good && !full) begin
        data       <= sr;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) par_bit <= rx_s;
      parity_err <= stop_smp & ~par_ok;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx at CLKS_PER_BIT = 16.
// A frame-level model predicts, for every frame sent, the clock edge at which
// its outcome appears and what the buffered byte and error pulses must be.
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Edges from driving the start bit to the edge that publishes the result:
  // 2 sync + 1 idle detect + CPB/2 start + (NBITS-2)*CPB data/parity + CPB stop.
  localparam int LAT = 3 + CPB / 2 + (NBITS - 1) * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b1;
  logic [7:0] data;
  logic       data_valid, framing_err, overrun_err, parity_err, busy;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .framing_err(framing_err), .overrun_err(overrun_err),
    .parity_err(parity_err), .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame outcome table: written by the stimulus, consumed by the model.
  int         ev_t [64];
  logic [7:0] ev_b [64];
  logic       ev_fe[64];
  logic       ev_pe[64];
  int         ev_wr = 0;
  int         ev_rd = 0;

  logic [7:0] m_data = '0;
  logic       m_valid = 1'b0, m_fe = 1'b0, m_ov = 1'b0, m_pe = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_data <= '0; m_valid <= 1'b0; m_fe <= 1'b0; m_ov <= 1'b0; m_pe <= 1'b0;
      ev_rd  <= ev_wr;
    end else begin
      m_fe <= 1'b0; m_ov <= 1'b0; m_pe <= 1'b0;
      if (ev_rd < ev_wr && ev_t[ev_rd] == cyc) begin
        ev_rd <= ev_rd + 1;
        m_fe  <= ev_fe[ev_rd];
        m_pe  <= ev_pe[ev_rd];
        if (!ev_fe[ev_rd] && !ev_pe[ev_rd]) begin
          if (m_valid && !data_ready) m_ov <= 1'b1;
          else begin m_data <= ev_b[ev_rd]; m_valid <= 1'b1; end
        end else if (m_valid && data_ready) m_valid <= 1'b0;
      end else if (m_valid && data_ready) m_valid <= 1'b0;
    end
  end

  int n_pass = 0, n_tot = 0, n_fail = 0;
  int n_rise = 0, n_fe = 0, n_ov = 0, n_pe = 0, n_vcyc = 0;
  logic [7:0] last_data = '0;
  logic       prev_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tx_bit(input logic v);
    rx = v;
    cycles(CPB);
  endtask

  // Caller is aligned 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    ev_t[ev_wr]  = cyc + LAT - 1;
    ev_b[ev_wr]  = b;
    ev_fe[ev_wr] = ~stop;
`ifdef UART_RX_PARITY_EN
    ev_pe[ev_wr] = ^b ^ par;
`else
    ev_pe[ev_wr] = 1'b0;
`endif
    ev_wr++;
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    tx_bit(par);
`endif
    tx_bit(stop);
  endtask

  int s_rise, s_fe, s_ov, s_pe, s_vcyc;
  task automatic snap();
    s_rise = n_rise; s_fe = n_fe; s_ov = n_ov; s_pe = n_pe; s_vcyc = n_vcyc;
  endtask

  initial begin
    fork
      begin : cmp
        forever begin
          @(negedge clk);
          if (rst_n) begin
            chk("data", data, m_data);
            chk("data_valid", data_valid, m_valid);
            chk("framing_err", framing_err, m_fe);
            chk("overrun_err", overrun_err, m_ov);
            chk("parity_err", parity_err, m_pe);
          end
          if (data_valid && !prev_valid) begin n_rise++; last_data = data; end
          prev_valid = data_valid;
          n_vcyc += int'(data_valid);
          n_fe   += int'(framing_err);
          n_ov   += int'(overrun_err);
          n_pe   += int'(parity_err);
        end
      end
      begin : seq
        cycles(3);
        chk("rst data", data, 8'h00);
        chk("rst data_valid", data_valid, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst framing_err", framing_err, 1'b0);
        chk("rst overrun_err", overrun_err, 1'b0);
        chk("rst parity_err", parity_err, 1'b0);
        rst_n = 1'b1;
        cycles(5);

        // Single byte with the consumer always ready.
        snap();
        send_frame(8'hA5, 1'b1, 1'b0);
        cycles(4);
        chk("a5 rise", n_rise - s_rise, 1);
        chk("a5 data", last_data, 8'hA5);
        chk("a5 valid cycles", n_vcyc - s_vcyc, 1);
        chk("a5 no framing", n_fe - s_fe, 0);
        chk("a5 no overrun", n_ov - s_ov, 0);
        chk("a5 no parity", n_pe - s_pe, 0);

        // Back-to-back with consumer stalled: second byte is dropped.
        data_ready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, ^8'hC3);
        cycles(4);
        chk("ovr data kept", data, 8'h3C);
        chk("ovr valid held", data_valid, 1'b1);
        chk("ovr pulses", n_ov - s_ov, 1);
        chk("ovr rise", n_rise - s_rise, 1);
        data_ready = 1'b1;
        cycles(1);
        chk("ovr consumed", data_valid, 1'b0);

        // Stop bit low followed by a long break.
        snap();
        send_frame(8'h55, 1'b0, 1'b0);
        cycles(40 * CPB);
        chk("brk busy", busy, 1'b1);
        chk("brk framing", n_fe - s_fe, 1);
        chk("brk no data", n_rise - s_rise, 0);
        rx = 1'b1;
        cycles(5);
        chk("brk idle", busy, 1'b0);
        chk("brk framing once", n_fe - s_fe, 1);

        // Short low glitch: a false start.
        snap();
        rx = 1'b0;
        cycles(6);
        rx = 1'b1;
        cycles(2);
        chk("glitch busy", busy, 1'b1);
        cycles(12);
        chk("glitch idle", busy, 1'b0);
        chk("glitch no data", n_rise - s_rise, 0);
        chk("glitch data", data, 8'h3C);
        chk("glitch no framing", n_fe - s_fe, 0);

        // All-zero and all-one bytes back-to-back.
        snap();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        cycles(4);
        chk("pat rises", n_rise - s_rise, 2);
        chk("pat data", last_data, 8'hFF);

        // Reset during data bit 4 of 0x99.
        tx_bit(1'b0);
        tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b0); tx_bit(1'b1);
        rx = 1'b1;
        cycles(CPB / 2);
        snap();
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", busy, 1'b0);
        chk("mid rst data", data, 8'h00);
        chk("mid rst valid", data_valid, 1'b0);
        cycles(3);
        rst_n = 1'b1;
        cycles(CPB);
        chk("mid rst no data", n_rise - s_rise, 0);
        chk("mid rst no framing", n_fe - s_fe, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        cycles(4);
        chk("post rst rise", n_rise - s_rise, 1);
        chk("post rst data", last_data, 8'h81);
        chk("post rst no framing", n_fe - s_fe, 0);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        cycles(4);
        chk("par bad pulse", n_pe - s_pe, 1);
        chk("par bad no data", n_rise - s_rise, 0);
        send_frame(8'h07, 1'b1, 1'b1);
        cycles(4);
        chk("par good rise", n_rise - s_rise, 1);
        chk("par good data", last_data, 8'h07);
        chk("par good once", n_pe - s_pe, 1);
`endif
        cycles(2);
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
